// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_e;

  localparam int DIV_ITERS = 32;

  // Divide-by-zero quotient is all ones at any width; hi returns the dividend.
  localparam logic DIV0_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] shift_next
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;
  logic           q_bit;

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    rem_next   = '0;
    shift_next = '0;
    q_bit      = 1'b0;
    partial    = {rem, shift[WIDTH-1]};
    diff       = partial - {1'b0, divisor};
    // A borrow out of the top bit means the divisor did not fit: restore.
    if (!diff[WIDTH]) begin
      q_bit    = 1'b1;
      rem_next = diff[WIDTH-1:0];
    end else begin
      rem_next = partial[WIDTH-1:0];
    end
    shift_next = {shift[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: MULT/MULTU, DIV/DIVU, MTHI/MTLO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] busa,
  input  logic [WIDTH-1:0] busb,
  input  logic             hilo_wr,
  input  logic             hilo_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_ITERS) ? MUL_CYCLES : DIV_ITERS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  op_e                op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quo_reg;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               div0;

  assign busy      = (state != IDLE);
  assign signed_op = op_reg[0];

  // Dividend magnitude is taken from the live inputs so the shift register loads at the start edge.
  assign a_mag_in  = (op[0] && busa[WIDTH-1]) ? (~busa + 1'b1) : busa;
  assign b_mag     = (signed_op && b_reg[WIDTH-1]) ? (~b_reg + 1'b1) : b_reg;

  // Sign- or zero-extend to 2*WIDTH so one multiplier serves MULT and MULTU.
  assign a_ext     = {{WIDTH{signed_op & a_reg[WIDTH-1]}}, a_reg};
  assign b_ext     = {{WIDTH{signed_op & b_reg[WIDTH-1]}}, b_reg};
  assign product   = a_ext * b_ext;

  // -2^(W-1) / -1 falls out naturally: magnitude quotient 2^(W-1), signs equal, no negation.
  assign quo_fix   = (signed_op && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])) ? (~quo_reg + 1'b1) : quo_reg;
  assign rem_fix   = (signed_op && a_reg[WIDTH-1]) ? (~rem_reg + 1'b1) : rem_reg;
  assign div0      = (b_reg == '0);

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem        (rem_reg),
    .shift      (quo_reg),
    .divisor    (b_mag),
    .rem_next   (rem_nxt),
    .shift_next (quo_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_reg  <= OP_MULTU;
      a_reg   <= '0;
      b_reg   <= '0;
      rem_reg <= '0;
      quo_reg <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= busa;
            b_reg   <= busb;
            op_reg  <= op_e'(op);
            rem_reg <= '0;
            quo_reg <= a_mag_in;
            if (op[1]) begin
              state <= DIV;
              cnt   <= CNT_W'(DIV_ITERS - 1);
            end else begin
              state <= MUL;
              cnt   <= CNT_W'(MUL_CYCLES - 1);
            end
          end else if (hilo_wr) begin
            if (hilo_sel) hi <= busa;
            else          lo <= busa;
          end
        end
        MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= product;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DIV: begin
          rem_reg <= rem_nxt;
          quo_reg <= quo_nxt;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (div0) begin
            lo <= {WIDTH{DIV0_FILL}};
            hi <= a_reg;
          end else begin
            lo <= quo_fix;
            hi <= rem_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int MUL_CYCLES = 5;
  localparam int WIDTH      = 32;
  localparam int DIV_EDGES  = 33;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] busa;
  logic [WIDTH-1:0] busb;
  logic             hilo_wr;
  logic             hilo_sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_unit #(.MUL_CYCLES(MUL_CYCLES), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .busa     (busa),
    .busb     (busb),
    .hilo_wr  (hilo_wr),
    .hilo_sel (hilo_sel),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} straight from the arithmetic definition of each operation.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     da, db;
    logic [31:0] q, r;
    case (o)
      2'b00: return {32'b0, a} * {32'b0, b};
      2'b01: begin
        sa = $signed(a);
        sb = $signed(b);
        return 64'(sa * sb);
      end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        da = $signed(a);
        db = $signed(b);
        q  = 32'(da / db);
        r  = 32'(da % db);
        return {r, q};
      end
    endcase
  endfunction

  task automatic move_to(input bit sel, input logic [31:0] data);
    @(negedge clk);
    hilo_wr = 1'b1; hilo_sel = sel; busa = data;
    @(posedge clk);
    @(negedge clk);
    hilo_wr = 1'b0;
    if (sel) exp_hi = data; else exp_lo = data;
    check("mt_hi", {32'b0, hi}, {32'b0, exp_hi});
    check("mt_lo", {32'b0, lo}, {32'b0, exp_lo});
  endtask

  // Issue one operation; optionally assert hilo_wr with start, or disturb mid-run.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit with_wr, input bit disturb);
    int          n, e;
    bit          seen, held;
    logic [63:0] r;
    r = model(o, a, b);
    n = o[1] ? DIV_EDGES : MUL_CYCLES;
    @(negedge clk);
    start = 1'b1; op = o; busa = a; busb = b; hilo_wr = with_wr; hilo_sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; hilo_wr = 1'b0;
    busa = $urandom; busb = $urandom;
    if (with_wr) check("wr_dropped", {32'b0, lo}, {32'b0, exp_lo});
    e = 0; seen = 1'b0; held = 1'b1;
    while (!seen && e < n + 5) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!busy || hi !== exp_hi || lo !== exp_lo) held = 1'b0;
        if (disturb && e == 2) begin
          start = 1'b1; hilo_wr = 1'b1; hilo_sel = 1'b1; busa = 32'h5555_5555; op = ~o;
        end else begin
          start = 1'b0; hilo_wr = 1'b0;
        end
        @(posedge clk);
        e++;
        @(negedge clk);
      end
    end
    start = 1'b0; hilo_wr = 1'b0;
    check("latency", 64'(e), 64'(n));
    check("busy_hold", {63'b0, held}, 64'd1);
    check("busy_at_done", {63'b0, busy}, 64'd0);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    check("hi", {32'b0, hi}, {32'b0, exp_hi});
    check("lo", {32'b0, lo}, {32'b0, exp_lo});
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", {63'b0, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; busa = '0; busb = '0;
    hilo_wr = 1'b0; hilo_sel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);

    // Directed cases, with the expected values stated independently of the model.
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_ff_hi", {32'b0, hi}, 64'hFFFF_FFFE);
    check("multu_ff_lo", {32'b0, lo}, 64'h0000_0001);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    check("mult_neg_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    check("mult_neg_lo", {32'b0, lo}, 64'hFFFF_FFF1);
    run_op(OP_MULTU, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    check("multu_neg_hi", {32'b0, hi}, 64'd4);
    check("multu_neg_lo", {32'b0, lo}, 64'hFFFF_FFF1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_m7_lo", {32'b0, lo}, 64'hFFFF_FFFD);
    check("div_m7_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    check("divu_100_lo", {32'b0, lo}, 64'd14);
    check("divu_100_hi", {32'b0, hi}, 64'd2);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf_lo", {32'b0, lo}, 64'h8000_0000);
    check("div_ovf_hi", {32'b0, hi}, 64'd0);

    move_to(1'b1, 32'hAAAA_0000);
    run_op(OP_MULTU, 32'd2, 32'd3, 1'b0, 1'b1);
    check("disturb_hi", {32'b0, hi}, 64'd0);
    check("disturb_lo", {32'b0, lo}, 64'd6);
    move_to(1'b0, 32'h0000_1111);
    run_op(OP_DIVU, 32'h0000_2222, 32'h11, 1'b1, 1'b0);

    run_op(OP_DIVU, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    check("div0_lo", {32'b0, lo}, 64'hFFFF_FFFF);
    check("div0_hi", {32'b0, hi}, 64'h0000_1234);

    // Asynchronous reset ten edges into a divide.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; busa = 32'hFFFF_FFF9; busb = 32'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_done", {63'b0, done}, 64'd0);
    check("arst_hi", {32'b0, hi}, 64'd0);
    check("arst_lo", {32'b0, lo}, 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    run_op(OP_MULTU, 32'd4, 32'd4, 1'b0, 1'b0);
    check("post_rst_lo", {32'b0, lo}, 64'd16);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(o, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
